pred_bimodal: RTL and testbench

- Parametrised successor to the single-entry fetch predictor.
- Generates the fetch PC (pc_out) to the icache.
- Predicts conditional branches from a direct-mapped, tagged table of 2-bit saturating counters, trained from the execute stage.
- Flags mispredicted decode-stage instructions for kill, and exposes branch/mispredict statistics counters.

---
 rtl/pred_bimodal.sv | 137 +++++++++++++
 tb/tb_pred_bimodal.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pred_bimodal.sv
// rtl/pred_bimodal.sv - fetch PC generator with a tagged bimodal branch table
// Lookup is on the decode PC; training comes from the execute stage.
module pred_bimodal #(
    parameter int              XLEN      = 32,
    parameter int              BHT_DEPTH = 64,
    parameter int              TAG_W     = 8,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(32'h8000_0000),
    parameter int              CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pipeline_en,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_dnpc,
    input  logic             is_ex_br,
    input  logic             is_br_taken,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_target,
    input  logic             id_target_en,
    input  logic             id_target_jump,
    output logic [XLEN-1:0]  pc_out,
    output logic             id_invalid,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [BHT_DEPTH-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q [BHT_DEPTH];
    logic [1:0]           ctr_q [BHT_DEPTH];

    logic [IDX_W-1:0] id_idx, ex_idx;
    logic [TAG_W-1:0] id_tag, ex_tag;
    logic             id_hit, ex_hit;
    logic             predict_taken;
    logic             id_correct;
    logic             train;
    logic [XLEN-1:0]  next_seq;
    logic             unused_ex_pc;

    assign id_idx = id_pc[IDX_W+1:2];
    assign id_tag = id_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign unused_ex_pc = ^ex_pc;

    assign id_hit        = valid_q[id_idx] && (tag_q[id_idx] == id_tag);
    assign ex_hit        = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign predict_taken = id_target_en && id_hit && ctr_q[id_idx][1];
    assign id_correct    = (id_pc == ex_dnpc);
    assign train         = (state_q == S_RUN) && pipeline_en && is_ex_br;

    assign next_seq = (id_target_jump || predict_taken) ? id_target : id_pc + XLEN'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_BOOT;
        end else if (pipeline_en) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_out     = RESET_PC;
        id_invalid = 1'b0;
        case (state_q)
            S_BOOT: begin
                state_d = S_FILL;
            end
            S_FILL: begin
                state_d = S_RUN;
                pc_out  = next_seq;
            end
            S_RUN: begin
                if (id_correct) begin
                    pc_out = next_seq;
                end else begin
                    state_d    = S_FILL;
                    pc_out     = ex_dnpc;
                    id_invalid = 1'b1;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    // Only the valid bits are reset; stale tags/counters are masked by valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (train) begin
            valid_q[ex_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (train) begin
            if (ex_hit) begin
                if (is_br_taken) begin
                    ctr_q[ex_idx] <= (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'b01;
                end else begin
                    ctr_q[ex_idx] <= (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'b01;
                end
            end else begin
                tag_q[ex_idx] <= ex_tag;
                ctr_q[ex_idx] <= is_br_taken ? 2'b10 : 2'b01;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt      <= '0;
            mispred_cnt <= '0;
        end else begin
            if (train && (br_cnt != '1)) begin
                br_cnt <= br_cnt + CNT_W'(1);
            end
            if (pipeline_en && (state_q == S_RUN) && !id_correct && (mispred_cnt != '1)) begin
                mispred_cnt <= mispred_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pred_bimodal.sv
// tb/tb_pred_bimodal.sv - directed and randomized bench for pred_bimodal
// Reference model: phase number plus arrays of valid/tag/counter values.
module tb_pred_bimodal;

    localparam int          XLEN      = 32;
    localparam int          BHT_DEPTH = 64;
    localparam int          TAG_W     = 8;
    localparam int          CNT_W     = 4;
    localparam int          IDX_W     = 6;
    localparam int          CNT_MAX   = 15;
    localparam logic [31:0] RST_PC    = 32'h8000_0000;

    logic             clk;
    logic             rst_n;
    logic             pipeline_en;
    logic [XLEN-1:0]  ex_pc, ex_dnpc, id_pc, id_target, pc_out;
    logic             is_ex_br, is_br_taken, id_target_en, id_target_jump, id_invalid;
    logic [CNT_W-1:0] br_cnt, mispred_cnt;

    pred_bimodal #(
        .XLEN(XLEN), .BHT_DEPTH(BHT_DEPTH), .TAG_W(TAG_W),
        .RESET_PC(RST_PC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pipeline_en(pipeline_en),
        .ex_pc(ex_pc), .ex_dnpc(ex_dnpc), .is_ex_br(is_ex_br), .is_br_taken(is_br_taken),
        .id_pc(id_pc), .id_target(id_target), .id_target_en(id_target_en),
        .id_target_jump(id_target_jump), .pc_out(pc_out), .id_invalid(id_invalid),
        .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    bit m_valid [BHT_DEPTH];
    int m_tag   [BHT_DEPTH];
    int m_ctr   [BHT_DEPTH];
    int m_phase;    // 0 boot, 1 fill, 2 run
    int m_br, m_mis;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, obs, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % BHT_DEPTH);
    endfunction

    function automatic int tag_of(input logic [31:0] pc);
        return int'((pc >> (2 + IDX_W)) % (1 << TAG_W));
    endfunction

    function automatic logic [31:0] rpc();
        return RST_PC | (32'($urandom_range(0, 1)) << 8) | (32'($urandom_range(0, 3)) << 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < BHT_DEPTH; i++) m_valid[i] = 0;
        m_phase = 0;
        m_br    = 0;
        m_mis   = 0;
    endtask

    // Starts and ends on a falling edge.
    task automatic step(input bit pe, input logic [31:0] xpc, input logic [31:0] xdn,
                        input bit br, input bit tk, input logic [31:0] ipc,
                        input logic [31:0] itg, input bit ten, input bit jmp,
                        input logic [31:0] want, input bit use_want);
        int i, j;
        bit hit, pt, correct;
        logic [31:0] nxt, exp_pc;
        pipeline_en = pe; ex_pc = xpc; ex_dnpc = xdn; is_ex_br = br; is_br_taken = tk;
        id_pc = ipc; id_target = itg; id_target_en = ten; id_target_jump = jmp;
        #1;
        i       = idx_of(ipc);
        hit     = m_valid[i] && (m_tag[i] == tag_of(ipc));
        pt      = ten && hit && (m_ctr[i] >= 2);
        nxt     = (jmp || pt) ? itg : ipc + 32'd4;
        correct = (ipc == xdn);
        exp_pc  = (m_phase == 0) ? RST_PC : ((m_phase == 2 && !correct) ? xdn : nxt);
        check("pc_out", pc_out, exp_pc);
        check("id_invalid", 32'(id_invalid), 32'(m_phase == 2 && !correct));
        check("br_cnt", 32'(br_cnt), 32'(m_br));
        check("mispred_cnt", 32'(mispred_cnt), 32'(m_mis));
        if (use_want) check("directed_pc", pc_out, want);
        @(posedge clk);
        if (pe) begin
            if (m_phase == 2 && br) begin
                j = idx_of(xpc);
                if (m_valid[j] && m_tag[j] == tag_of(xpc)) begin
                    m_ctr[j] = tk ? ((m_ctr[j] < 3) ? m_ctr[j] + 1 : 3)
                                  : ((m_ctr[j] > 0) ? m_ctr[j] - 1 : 0);
                end else begin
                    m_valid[j] = 1;
                    m_tag[j]   = tag_of(xpc);
                    m_ctr[j]   = tk ? 2 : 1;
                end
                if (m_br < CNT_MAX) m_br++;
            end
            if (m_phase == 2 && !correct && m_mis < CNT_MAX) m_mis++;
            m_phase = (m_phase == 0) ? 1 : ((m_phase == 1) ? 2 : (correct ? 2 : 1));
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_pc_out", pc_out, RST_PC);
        check("rst_id_invalid", 32'(id_invalid), 32'd0);
        check("rst_br_cnt", 32'(br_cnt), 32'd0);
        check("rst_mispred_cnt", 32'(mispred_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] a, d;
        rst_n = 1'b0; pipeline_en = 1'b1; ex_pc = RST_PC; ex_dnpc = RST_PC; is_ex_br = 1'b0;
        is_br_taken = 1'b0; id_pc = RST_PC; id_target = '0; id_target_en = 1'b0; id_target_jump = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("in_reset_pc", pc_out, RST_PC);
        rst_n = 1'b1;

        // boot, training, hysteresis, alias, mispredict
        step(1, RST_PC,        RST_PC,        0, 0, RST_PC,        0,      0, 0, RST_PC,        1);
        step(1, RST_PC,        RST_PC,        0, 0, RST_PC,        0,      0, 0, 32'h8000_0004, 1);
        step(1, 32'h8000_0010, RST_PC,        1, 1, RST_PC,        0,      0, 0, 32'h8000_0004, 1);
        step(1, 32'h8000_0010, RST_PC,        1, 1, RST_PC,        0,      0, 0, 32'h8000_0004, 1);
        check("br_cnt_two", 32'(br_cnt), 32'd2);
        step(1, RST_PC,        32'h8000_0010, 0, 0, 32'h8000_0010, RST_PC, 1, 0, RST_PC,        1);
        step(1, 32'h8000_0010, 32'h8000_0010, 1, 0, 32'h8000_0010, RST_PC, 1, 0, RST_PC,        1);
        step(1, 32'h8000_0010, 32'h8000_0010, 1, 0, 32'h8000_0010, RST_PC, 1, 0, RST_PC,        1);
        step(1, RST_PC,        32'h8000_0010, 0, 0, 32'h8000_0010, RST_PC, 1, 0, 32'h8000_0014, 1);
        step(1, 32'h8000_0110, 32'h8000_0110, 1, 0, 32'h8000_0110, RST_PC, 1, 0, 32'h8000_0114, 1);
        step(1, RST_PC,        32'h8000_0010, 0, 0, 32'h8000_0010, RST_PC, 1, 0, 32'h8000_0014, 1);
        step(0, RST_PC,        RST_PC,        0, 0, 32'h8000_0014, 0,      0, 0, RST_PC,        1);
        step(0, RST_PC,        RST_PC,        0, 0, 32'h8000_0014, 0,      0, 0, RST_PC,        1);
        step(1, RST_PC,        RST_PC,        0, 0, 32'h8000_0014, 0,      0, 0, RST_PC,        1);
        check("mispred_one", 32'(mispred_cnt), 32'd1);
        step(1, RST_PC,        32'h8000_0020, 0, 0, 32'h8000_0020, 0,      0, 0, 32'h8000_0024, 1);
        step(1, 32'h8000_0010, 32'h8000_0020, 1, 1, 32'h8000_0020, 0,      0, 0, 32'h8000_0024, 1);
        step(1, 32'h8000_0010, 32'h8000_0020, 1, 1, 32'h8000_0020, 0,      0, 0, 32'h8000_0024, 1);

        // async reset mid-run, then the trained branch must not be predicted
        do_reset();
        step(1, RST_PC, RST_PC,        0, 0, RST_PC,        0,      0, 0, RST_PC,        1);
        step(1, RST_PC, RST_PC,        0, 0, RST_PC,        0,      0, 0, 32'h8000_0004, 1);
        step(1, RST_PC, 32'h8000_0010, 0, 0, 32'h8000_0010, RST_PC, 1, 0, 32'h8000_0014, 1);

        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                a = rpc();
                d = ($urandom_range(0, 3) != 0) ? a : rpc();
                step($urandom_range(0, 6) != 0, rpc(), d, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 2) != 0, a, rpc(), $urandom_range(0, 1) == 1,
                     $urandom_range(0, 7) == 0, '0, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
